// File: rtl/pllsup_pkg.sv
// pllsup_pkg: shared states, default parameters and helpers for the PLL lock supervisor.
package pllsup_pkg;

    typedef enum logic [2:0] {HOLD, WAIT, STABLE, RUN, FAIL} state_e;

    localparam int DEF_RST_HOLD_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT       = 16000;
    localparam int DEF_LOCK_STABLE_CYCLES = 256;
    localparam int DEF_LOSS_FILTER        = 4;
    localparam int DEF_MAX_RETRIES        = 3;

    localparam int LOSS_W = 8;
    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, proves lock stability and gates the fabric reset.
// Optional lock-loss event counter enabled by defining PLLSUP_LOSS_CNT_EN.
module pll_lock_supervisor
    import pllsup_pkg::*;
#(
    parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int LOSS_FILTER        = DEF_LOSS_FILTER,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
    localparam int RW = $clog2(MAX_RETRIES + 1)
) (
    input  logic              REFERENCECLK,
    input  logic              RESET,
    input  logic              LOCK,
    input  logic              RETRY,
    output logic              PLL_RESETB,
    output logic              SYS_RESET,
    output logic              PLL_READY,
    output logic              PLL_FAIL,
    output logic [RW-1:0]     RETRY_COUNT,
    output logic [LOSS_W-1:0] LOSS_COUNT
);

    localparam int TW = $clog2(max2(LOCK_TIMEOUT, RST_HOLD_CYCLES) + 1);
    localparam int CW = $clog2(max2(LOCK_STABLE_CYCLES, LOSS_FILTER) + 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            resetb_q, sys_reset_q, ready_q, fail_q;
    logic            lock_s;

    sync_2ff u_lock_sync (
        .clk_i (REFERENCECLK),
        .rst_i (RESET),
        .d_i   (LOCK),
        .q_o   (lock_s)
    );

    // Timer is shared: HOLD duration, then cumulative attempt time across WAIT and STABLE.
    // cnt is shared: stable-lock run length in STABLE, dropout filter in RUN.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            HOLD: begin
                if (timer_q == TW'(RST_HOLD_CYCLES - 1)) begin
                    state_d = WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT, STABLE: begin
                timer_d = timer_q + 1'b1;
                if (state_q == WAIT) begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = CW'(1);
                    end
                end else if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (state_d != RUN && timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    if (retry_q == RW'(MAX_RETRIES)) begin
                        state_d = FAIL;
                    end else begin
                        state_d = HOLD;
                        retry_d = retry_q + 1'b1;
                    end
                end
            end
            RUN: begin
                timer_d = '0;
                if (RETRY) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(LOSS_FILTER - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAIL: begin
                timer_d = '0;
                cnt_d   = '0;
                if (RETRY) begin
                    state_d = HOLD;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = HOLD;
                timer_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they move with the state register.
    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= HOLD;
            timer_q     <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            resetb_q    <= 1'b0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            resetb_q    <= (state_d == WAIT) || (state_d == STABLE) || (state_d == RUN);
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign PLL_RESETB  = resetb_q;
    assign SYS_RESET   = sys_reset_q;
    assign PLL_READY   = ready_q;
    assign PLL_FAIL    = fail_q;
    assign RETRY_COUNT = retry_q;

`ifdef PLLSUP_LOSS_CNT_EN
    logic              loss_ev;
    logic [LOSS_W-1:0] loss_q;

    assign loss_ev = (state_q == RUN) && (state_d == HOLD) && !RETRY;

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
        if (RESET) begin
            loss_q <= '0;
        end else if (loss_ev && loss_q != LOSS_MAX) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign LOSS_COUNT = loss_q;
`else
    assign LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard-checked acquisition, retry, failure and lock-loss scenarios.
module tb_pll_lock_supervisor;

    localparam int RH = 4;
    localparam int TO = 64;
    localparam int ST = 8;
    localparam int LF = 4;
    localparam int MR = 2;
`ifdef PLLSUP_LOSS_CNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       retry = 1'b0;
    logic       pll_resetb, sys_reset, pll_ready, pll_fail;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES    (RH),
        .LOCK_TIMEOUT       (TO),
        .LOCK_STABLE_CYCLES (ST),
        .LOSS_FILTER        (LF),
        .MAX_RETRIES        (MR)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (rst),
        .LOCK         (lock),
        .RETRY        (retry),
        .PLL_RESETB   (pll_resetb),
        .SYS_RESET    (sys_reset),
        .PLL_READY    (pll_ready),
        .PLL_FAIL     (pll_fail),
        .RETRY_COUNT  (retry_count),
        .LOSS_COUNT   (loss_count)
    );

    typedef struct {
        string name;
        int    exp;
    } sb_t;

    typedef struct {
        int drop;
        int stay;
    } vec_t;

    sb_t  sbq[$];
    vec_t vt[5];
    int   total = 0;
    int   bad = 0;
    int   exp_loss = 0;

    function automatic void push(input string n, input int e);
        sbq.push_back('{n, e});
    endfunction

    task automatic check(input int act);
        sb_t s;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=%0d", act);
        end else begin
            s = sbq.pop_front();
            if (act != s.exp) begin
                bad++;
                $display("FAIL %s got=%0d want=%0d", s.name, act, s.exp);
            end
        end
    endtask

    task automatic chk(input string n, input int act, input int e);
        push(n, e);
        check(act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_len(output int n);
        logic v;
        v = pll_resetb;
        n = 0;
        while (pll_resetb == v && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!pll_ready && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lock = 1'b0;
        retry = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_retry();
        retry = 1'b1;
        tick();
        retry = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_resetb"}, pll_resetb, 0);
        chk({tag, "_sys_reset"}, sys_reset, 1);
        chk({tag, "_ready"}, pll_ready, 0);
        chk({tag, "_fail"}, pll_fail, 0);
        chk({tag, "_retry_count"}, retry_count, 0);
        chk({tag, "_loss_count"}, loss_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        vt[0] = '{1, 1};
        vt[1] = '{2, 1};
        vt[2] = '{3, 1};
        vt[3] = '{4, 0};
        vt[4] = '{6, 0};

        tick();
        tick();
        chk_reset_vals("por");

        // clean lock
        rst = 1'b0;
        run_len(n);
        chk("hold_len", n, RH);
        repeat (10) tick();
        lock = 1'b1;
        wait_ready(n);
        chk("lock_latency", n, 2 + ST);
        chk("run_sys_reset", sys_reset, 0);
        chk("run_retry_count", retry_count, 0);
        chk("run_resetb", pll_resetb, 1);

        // RETRY in RUN forces re-lock without a loss event
        pulse_retry();
        chk("retry_run_ready", pll_ready, 0);
        chk("retry_run_resetb", pll_resetb, 0);
        chk("retry_run_sys_reset", sys_reset, 1);
        chk("retry_run_loss", loss_count, exp_loss);
        wait_ready(n);
        chk("retry_run_reacq", pll_ready, 1);

        // dropout filter table
        foreach (vt[i]) begin
            lock = 1'b0;
            repeat (vt[i].drop) tick();
            lock = 1'b1;
            repeat (3) tick();
            if (vt[i].stay == 0) exp_loss += LOSS_EN;
            push($sformatf("drop%0d_ready", vt[i].drop), vt[i].stay);
            push($sformatf("drop%0d_sys_reset", vt[i].drop), 1 - vt[i].stay);
            push($sformatf("drop%0d_loss", vt[i].drop), exp_loss);
            check(pll_ready);
            check(sys_reset);
            check(loss_count);
            wait_ready(n);
            chk($sformatf("drop%0d_reacq", vt[i].drop), pll_ready, 1);
        end

        // RETRY in WAIT is ignored
        lock = 1'b0;
        pulse_retry();
        run_len(n);
        chk("retry_hold_len", n, RH);
        pulse_retry();
        chk("retry_wait_resetb", pll_resetb, 1);
        chk("retry_wait_fail", pll_fail, 0);
        chk("retry_wait_loss", loss_count, exp_loss);

        // no lock: three attempts then FAIL
        do_reset();
        for (int k = 0; k <= MR; k++) begin
            push($sformatf("nolock_hold%0d", k), RH);
            push($sformatf("nolock_rc%0d", k), k);
            push($sformatf("nolock_wait%0d", k), TO);
        end
        push("fail_flag", 1);
        push("fail_resetb", 0);
        push("fail_rc", MR);
        push("fail_sys_reset", 1);
        for (int k = 0; k <= MR; k++) begin
            run_len(n);
            check(n);
            check(retry_count);
            run_len(n);
            check(n);
        end
        check(pll_fail);
        check(pll_resetb);
        check(retry_count);
        check(sys_reset);
        repeat (20) tick();
        chk("fail_sticky", pll_fail, 1);
        pulse_retry();
        chk("fail_retry_rc", retry_count, 0);
        chk("fail_retry_flag", pll_fail, 0);
        chk("fail_retry_resetb", pll_resetb, 0);
        run_len(n);
        chk("fail_retry_hold", n, RH);

        // chatter in STABLE never reaches RUN
        do_reset();
        run_len(n);
        n = 0;
        seen = 0;
        while (pll_resetb && n < 100) begin
            if (n % 5 == 0) lock = ((n / 5) % 2 == 0);
            tick();
            n++;
            if (pll_ready) seen = 1;
        end
        chk("chatter_len", n, TO);
        chk("chatter_ready_seen", seen, 0);
        chk("chatter_rc", retry_count, 1);

        // asynchronous reset mid-STABLE
        do_reset();
        run_len(n);
        lock = 1'b1;
        repeat (7) tick();
        chk("stable_not_ready", pll_ready, 0);
        chk("stable_resetb", pll_resetb, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        rst = 1'b0;
        run_len(n);
        chk("reacq_hold", n, RH);
        wait_ready(n);
        chk("reacq_stable", n, ST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
